// File: rtl/plru_pkg.sv
// Shared definitions for the tree pseudo-LRU way controller: request opcodes
// and the request-serialising FSM state type.
package plru_pkg;

    localparam logic OP_TOUCH = 1'b0;
    localparam logic OP_ALLOC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        UPDATE
    } plru_state_t;

endpackage

// File: rtl/plru_onehot_encoder.sv
// One-hot to binary encoder with a validity flag. The flag is high only when
// exactly one input bit is set; any other pattern yields index 0.
module plru_onehot_encoder #(
    parameter  int WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  in,
    output logic [WAY_W-1:0] out,
    output logic             onehot
);

    int               count;
    logic [WAY_W-1:0] idx;

    // Count set bits and remember the index of the last one seen.
    always_comb begin
        count = 0;
        idx   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (in[i]) begin
                count = count + 1;
                idx   = WAY_W'(i);
            end
        end
        onehot = (count == 1);
        out    = onehot ? idx : '0;
    end

endmodule

// File: rtl/plru_way_controller.sv
// Tree pseudo-LRU replacement controller. Serialises TOUCH (hit) and ALLOC
// (miss) requests through IDLE -> READ -> UPDATE, one request every 3 cycles.
// Optional build macro PLRU_STATS_EN adds saturating touch/alloc counters.
module plru_way_controller
    import plru_pkg::*;
#(
    parameter  int WAYS  = 8,
    parameter  int SETS  = 64,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAYS-1:0]  req_hit_way,
    output logic             rsp_valid,
    output logic [WAY_W-1:0] rsp_way,
    output logic             rsp_err
`ifdef PLRU_STATS_EN
    ,
    output logic [31:0]      stat_touch_cnt,
    output logic [31:0]      stat_alloc_cnt
`endif
);

    plru_state_t      state;
    plru_state_t      state_next;

    logic             op_p0;
    logic [SET_W-1:0] set_p0;
    logic [WAYS-1:0]  hit_p0;

    logic [WAYS-2:0]  plru_mem [SETS];
    logic [WAYS-2:0]  row_p0;
    logic [WAYS-2:0]  bits_p1;
    logic [WAY_W-1:0] way_p1;
    logic             wr_en_p1;

    logic [WAY_W-1:0] hit_idx;
    logic             hit_onehot;
    logic [WAY_W-1:0] target_way;
    logic             target_err;
    logic             accept;

    // Walk from the root following each node's bit; the leaf reached is the victim.
    function automatic logic [WAY_W-1:0] find_victim(input logic [WAYS-2:0] bits);
        int node;
        node = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            node = 2 * node + int'(bits[node-1]);
        end
        return WAY_W'(node - WAYS);
    endfunction

    // Point every node on the path to 'way' away from it; other nodes keep their value.
    function automatic logic [WAYS-2:0] touch_path(input logic [WAYS-2:0] bits,
                                                    input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] nb;
        logic            upper;
        int              node;
        nb   = bits;
        node = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            upper        = way[WAY_W-1-lvl];
            nb[node-1]   = ~upper;
            node         = 2 * node + int'(upper);
        end
        return nb;
    endfunction

    plru_onehot_encoder #(
        .WAYS(WAYS)
    ) u_hit_enc (
        .in     (hit_p0),
        .out    (hit_idx),
        .onehot (hit_onehot)
    );

    assign accept     = req_valid && req_ready;
    assign row_p0     = plru_mem[set_p0];
    assign target_err = (op_p0 == OP_TOUCH) && !hit_onehot;
    assign target_way = (op_p0 == OP_ALLOC) ? find_victim(row_p0) : hit_idx;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the controller only accepts a request from IDLE.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = READ;
            end
            READ:    state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0/p1 datapath capture: request on accept, set row and target way during READ.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0  <= req_op;
            set_p0 <= req_set;
            hit_p0 <= req_hit_way;
        end
        if (state == READ) begin
            bits_p1 <= row_p0;
            way_p1  <= target_way;
        end
    end

    // Response registers: loaded leaving READ so the strobe coincides with UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_way   <= '0;
            rsp_err   <= 1'b0;
            wr_en_p1  <= 1'b0;
        end else begin
            rsp_valid <= (state == READ);
            if (state == READ) begin
                rsp_way  <= target_way;
                rsp_err  <= target_err;
                wr_en_p1 <= !target_err;
            end
        end
    end

    // PLRU state array; written back in UPDATE unless the touch was malformed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                plru_mem[s] <= '0;
            end
        end else if ((state == UPDATE) && wr_en_p1) begin
            plru_mem[set_p0] <= touch_path(bits_p1, way_p1);
        end
    end

`ifdef PLRU_STATS_EN
    // Saturating counters bumped alongside the response being produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_touch_cnt <= '0;
            stat_alloc_cnt <= '0;
        end else if (state == READ) begin
            if ((op_p0 == OP_ALLOC) && (stat_alloc_cnt != 32'hFFFF_FFFF)) begin
                stat_alloc_cnt <= stat_alloc_cnt + 32'd1;
            end
            if ((op_p0 == OP_TOUCH) && !target_err && (stat_touch_cnt != 32'hFFFF_FFFF)) begin
                stat_touch_cnt <= stat_touch_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_plru_way_controller.sv
// Self-checking bench for plru_way_controller (WAYS=8, SETS=4) with a
// per-cycle reference model and hand-computed directed expectations.
module tb_plru_way_controller;

    localparam int WAYS  = 8;
    localparam int SETS  = 4;
    localparam int WAY_W = 3;
    localparam int SET_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_op = 1'b0;
    logic [SET_W-1:0] req_set = '0;
    logic [WAYS-1:0]  req_hit_way = '0;
    logic             rsp_valid;
    logic [WAY_W-1:0] rsp_way;
    logic             rsp_err;

    always #5 clk = ~clk;

    plru_way_controller #(
        .WAYS(WAYS),
        .SETS(SETS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_set     (req_set),
        .req_hit_way (req_hit_way),
        .rsp_valid   (rsp_valid),
        .rsp_way     (rsp_way),
        .rsp_err     (rsp_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct { int cyc; int way; int err; } exp_t;
    typedef struct { int way; int err; } obs_t;
    exp_t exp_q[$];
    obs_t log_q[$];

    // Model state: tree[s][n] is heap node n of set s (1 = victim in upper half).
    bit tree [SETS][16];
    int next_free = 0;
    int last_way = 0;
    int last_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int m_victim(input int s);
        int lo = 0;
        int sz = WAYS;
        int n = 1;
        while (sz > 1) begin
            sz = sz / 2;
            if (tree[s][n]) begin
                lo = lo + sz;
                n = 2 * n + 1;
            end else begin
                n = 2 * n;
            end
        end
        return lo;
    endfunction

    function automatic void m_touch(input int s, input int w);
        int lo = 0;
        int sz = WAYS;
        int n = 1;
        while (sz > 1) begin
            sz = sz / 2;
            if (w < lo + sz) begin
                tree[s][n] = 1'b1;
                n = 2 * n;
            end else begin
                tree[s][n] = 1'b0;
                lo = lo + sz;
                n = 2 * n + 1;
            end
        end
    endfunction

    // Compare process: every negedge, check DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int n = 0; n < 16; n++) tree[s][n] = 1'b0;
            exp_q.delete();
            next_free = 0;
            last_way = 0;
            last_err = 0;
            check("reset_rsp_valid", rsp_valid, 0);
            check("reset_req_ready", req_ready, 1);
            check("reset_rsp_way", rsp_way, 0);
            check("reset_rsp_err", rsp_err, 0);
        end else begin
            check("req_ready", req_ready, (cyc >= next_free) ? 1 : 0);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                check("rsp_valid_strobe", rsp_valid, 1);
                check("rsp_way", rsp_way, exp_q[0].way);
                check("rsp_err", rsp_err, exp_q[0].err);
                last_way = exp_q[0].way;
                last_err = exp_q[0].err;
                void'(exp_q.pop_front());
            end else begin
                check("rsp_valid_quiet", rsp_valid, 0);
                check("rsp_way_hold", rsp_way, last_way);
                check("rsp_err_hold", rsp_err, last_err);
            end
            if (rsp_valid) log_q.push_back('{way: int'(rsp_way), err: int'(rsp_err)});
            if (req_valid && cyc >= next_free) begin
                int s;
                int w;
                int e;
                s = int'(req_set);
                w = 0;
                e = 0;
                if (req_op) begin
                    w = m_victim(s);
                    m_touch(s, w);
                end else if ($countones(req_hit_way) == 1) begin
                    for (int i = 0; i < WAYS; i++) if (req_hit_way[i]) w = i;
                    m_touch(s, w);
                end else begin
                    e = 1;
                end
                exp_q.push_back('{cyc: cyc + 2, way: w, err: e});
                next_free = cyc + 3;
            end
        end
    end

    task automatic do_req(input bit op, input int set, input logic [WAYS-1:0] hit);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op = op;
        req_set = SET_W'(set);
        req_hit_way = hit;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: req_ready stayed 0, expected 1 within 20 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        log_q.delete();
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
    endtask

    task automatic chk_resp(input string name, input int i, input int way, input int err);
        if (i >= log_q.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: response %0d missing, got %0d responses", name, i, log_q.size());
        end else begin
            check({name, "_way"}, log_q[i].way, way);
            check({name, "_err"}, log_q[i].err, err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pulses;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Four ALLOCs to set 0 from reset: 0, 4, 2, 6.
        log_q.delete();
        for (int i = 0; i < 4; i++) do_req(1'b1, 0, '0);
        drain();
        chk_resp("alloc_seq0", 0, 0, 0);
        chk_resp("alloc_seq1", 1, 4, 0);
        chk_resp("alloc_seq2", 2, 2, 0);
        chk_resp("alloc_seq3", 3, 6, 0);

        // TOUCH way 0 then ALLOC in set 1.
        do_reset();
        do_req(1'b0, 1, 8'h01);
        do_req(1'b1, 1, '0);
        drain();
        chk_resp("touch_w0", 0, 0, 0);
        chk_resp("alloc_after_touch", 1, 4, 0);

        // Malformed hit vectors report an error and leave state alone.
        do_reset();
        do_req(1'b0, 2, 8'h03);
        do_req(1'b0, 2, 8'h00);
        do_req(1'b1, 2, '0);
        drain();
        chk_resp("touch_multihot", 0, 0, 1);
        chk_resp("touch_zero", 1, 0, 1);
        chk_resp("alloc_after_err", 2, 0, 0);

        // Sets are isolated.
        do_reset();
        do_req(1'b1, 0, '0);
        do_req(1'b1, 0, '0);
        do_req(1'b1, 3, '0);
        drain();
        chk_resp("iso_a", 0, 0, 0);
        chk_resp("iso_b", 1, 4, 0);
        chk_resp("iso_set3", 2, 0, 0);

        // Reset during READ drops the response and clears the tree.
        log_q.delete();
        do_req(1'b1, 0, '0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drain();
        check("rst_mid_no_rsp", log_q.size(), 0);
        do_req(1'b1, 0, '0);
        drain();
        chk_resp("alloc_after_mid_rst", 0, 0, 0);

        // req_valid held for 9 cycles: ready 1,0,0 repeating, 3 accepts, 3 responses.
        log_q.delete();
        acc = 0;
        pulses = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op = 1'b1;
        req_set = 2'd1;
        req_hit_way = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("held_ready_%0d", i), req_ready, (i % 3 == 0) ? 1 : 0);
            if (req_ready) acc++;
            if (rsp_valid) pulses++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();
        check("held_accepts", acc, 3);
        check("held_pulses", pulses, 3);
        chk_resp("held_rsp0", 0, 0, 0);
        chk_resp("held_rsp1", 1, 4, 0);
        chk_resp("held_rsp2", 2, 2, 0);

        check("pending_responses", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plru_way_controller.md
Name: plru_way_controller

Overview:
- Tree pseudo-LRU replacement controller for the set-associative L2 model.
- Holds per-set PLRU state and serialises two request types:
  - touch: a hit updates recency.
  - allocate: a miss returns a victim way and marks it most-recently-used.
- Sits beside the tag array. It takes the one-hot way-hit vector from tag compare and produces a binary way index for the data array.

Parameters:
- WAYS, 8, associativity. Power of two, at least 2. WAY_W = $clog2(WAYS).
- SETS, 64, number of sets. Power of two. SET_W = $clog2(SETS).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept. High only in IDLE.
- req_op  input  1  0 = TOUCH, 1 = ALLOC.
- req_set  input  SET_W  set index.
- req_hit_way  input  WAYS  one-hot hit vector. Used by TOUCH only.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_way  output  WAY_W  ALLOC: victim way. TOUCH: encoded hit way.
- rsp_err  output  1  TOUCH with a non-one-hot hit vector.

Behaviour:
- Reset values:
  - All SETS x (WAYS-1) PLRU bits = 0.
  - State = IDLE.
  - rsp_valid = 0, rsp_way = 0, rsp_err = 0, req_ready = 1.
- Tree layout: heap indexing, root node 1, children 2n and 2n+1, node n stored at bit n-1.
  - Bit = 0: victim lies in the lower-numbered subtree.
  - Bit = 1: victim lies in the upper subtree.
- Victim search: start at the root and follow the bits down to a leaf.
- Touch of way w: every node on w's path is set to point away from w.
  - If w is in a node's lower subtree, that bit is set to 1; otherwise 0.
  - Nodes off the path are unchanged.
- FSM states: IDLE -> READ -> UPDATE -> IDLE.
  - IDLE: req_ready = 1. On req_valid & req_ready, register op, set and hit vector, then go to READ.
  - READ: read the set's PLRU bits into a register. req_ready = 0.
  - UPDATE: compute the result, write back the new bits, then go to IDLE. rsp_valid = 1 for exactly this cycle; rsp_way and rsp_err are registered with it.
- Latency: request accepted in cycle 0, response in cycle 2. At most one request every 3 cycles.
- TOUCH rules:
  - If the hit vector is one-hot: rsp_way = encoded index, rsp_err = 0, path bits updated.
  - If the vector is zero or multi-hot: rsp_err = 1, rsp_way = 0, no state write.
- ALLOC: rsp_way = victim from the current bits, rsp_err = 0, then the victim's path is touched.
- Requests are strictly serialised. Back-to-back requests to the same set always see the previous update.
- Inputs are ignored outside IDLE. The requester holds the request until req_ready.
- Reset mid-operation (READ or UPDATE): go to IDLE immediately, clear all bits, drop the response (no rsp_valid).
- rsp_way and rsp_err hold their last values between strobes.

Optional Feature:
- Macro: PLRU_STATS_EN.
- When defined, two extra outputs are added:
  - stat_touch_cnt [31:0]
  - stat_alloc_cnt [31:0]
- Counter rules:
  - stat_touch_cnt increments on each TOUCH response with rsp_err = 0.
  - stat_alloc_cnt increments on each ALLOC response.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and counters do not exist and the rest of the behaviour is identical.

Decomposition:
- Package plru_pkg holds:
  - op constants OP_TOUCH = 1'b0, OP_ALLOC = 1'b1;
  - the FSM state enum {IDLE, READ, UPDATE}.
- Sub-module plru_onehot_encoder, parameterised by WAYS. It is purely combinational:
  - in [WAYS-1:0] -> out [WAY_W-1:0] plus an onehot flag;
  - onehot = 1 only for exactly one set bit; otherwise out = 0.
- Victim search and path update are for-loops inside plru_way_controller.

Test Plan (WAYS=8, SETS=4):
- Reset, then four ALLOCs to set 0 -> rsp_way = 0, 4, 2, 6, each strobe 2 cycles after its accept.
- Reset, TOUCH set 1 with hit 8'h01, then ALLOC set 1 -> TOUCH rsp_way = 0, rsp_err = 0; ALLOC rsp_way = 4.
- Reset, TOUCH set 2 with hit 8'h03, then hit 8'h00 -> rsp_err = 1, rsp_way = 0 both times; next ALLOC set 2 -> way 0 (no state change).
- ALLOC set 0 twice, then ALLOC set 3 -> set 3 returns way 0 (sets are isolated).
- Accept ALLOC set 0, pull rst_n low during READ, release -> no rsp_valid; next ALLOC set 0 -> way 0.
- req_valid held high for 9 cycles -> req_ready pattern 1,0,0 repeating; exactly 3 accepts and 3 rsp_valid pulses.
